// File: rtl/ahb_lite_arbiter.sv
// Round-robin arbiter sharing one AHB-lite slave port between NUM_MASTERS
// masters. Ownership is granted per transfer or per burst. Defined-length
// bursts are never split. INCR bursts are capped at MAX_HOLD beats when
// another master is waiting. Produces the address-phase owner (HMASTER) and
// the data-phase owner (HMASTER_D), which lags by one accepted transfer.
module ahb_lite_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     clk,
  input  logic                     HRESET,
  input  logic [NUM_MASTERS-1:0]   HBUSREQ,
  input  logic [2*NUM_MASTERS-1:0] HTRANS_M,
  input  logic [3*NUM_MASTERS-1:0] HBURST_M,
  input  logic                     HREADY,
  output logic [NUM_MASTERS-1:0]   HGRANT,
  output logic [MID_W-1:0]         HMASTER,
  output logic [MID_W-1:0]         HMASTER_D,
  output logic                     HDATA_VALID
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_INCR = 3'b001;

  // Counter must hold both the longest defined burst (16) and MAX_HOLD.
  localparam int LOAD_MAX = (MAX_HOLD > 16) ? MAX_HOLD : 16;
  localparam int CNT_W    = $clog2(LOAD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MAX_HOLD);

  logic [1:0]       state_q, state_d;
  logic [MID_W-1:0] hmaster_q, hmaster_d;
  logic [MID_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             incr_q, incr_d;
  logic [MID_W-1:0] dmaster_q;
  logic             dvalid_q;

  logic [1:0]             trans_arr [NUM_MASTERS];
  logic [2:0]             burst_arr [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic [1:0]             t_own;
  logic [2:0]             b_own;
  logic                   grant_active;
  logic                   others_pend;
  logic                   arb_found;
  logic [MID_W-1:0]       arb_idx;
  logic                   rearb;
  logic [CNT_W-1:0]       load_len;

  // Unpack per-master control fields and build the owner one-hot mask.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign trans_arr[gi]    = HTRANS_M[2*gi +: 2];
    assign burst_arr[gi]    = HBURST_M[3*gi +: 3];
    assign owner_onehot[gi] = (hmaster_q == MID_W'(gi));
  end

  assign grant_active = (state_q != ST_IDLE);
  assign t_own        = trans_arr[hmaster_q];
  assign b_own        = burst_arr[hmaster_q];
  assign others_pend  = |(HBUSREQ & ~owner_onehot);

  assign HGRANT      = grant_active ? owner_onehot : '0;
  assign HMASTER     = hmaster_q;
  assign HMASTER_D   = dmaster_q;
  assign HDATA_VALID = dvalid_q;

  // Beat count for a burst type; INCR gets the hold cap, unknown codes act as SINGLE.
  function automatic logic [CNT_W-1:0] burst_len(input logic [2:0] b);
    case (b)
      3'b001:         burst_len = HOLD_LOAD;
      3'b010, 3'b011: burst_len = CNT_W'(4);
      3'b100, 3'b101: burst_len = CNT_W'(8);
      3'b110, 3'b111: burst_len = CNT_W'(16);
      default:        burst_len = CNT_W'(1);
    endcase
  endfunction

  // Round-robin search starting just after the last winner; the last winner ranks last.
  always_comb begin
    int cand;
    arb_found = 1'b0;
    arb_idx   = rr_q;
    cand      = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = (int'(rr_q) + i) % NUM_MASTERS;
      if (!arb_found && HBUSREQ[cand]) begin
        arb_found = 1'b1;
        arb_idx   = MID_W'(cand);
      end
    end
  end

  // Ownership FSM; nothing moves unless the current transfer is accepted.
  always_comb begin
    state_d   = state_q;
    hmaster_d = hmaster_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    incr_d    = incr_q;
    rearb     = 1'b0;
    load_len  = burst_len(b_own);
    if (HREADY) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            state_d   = ST_OWNED;
            hmaster_d = arb_idx;
            rr_d      = arb_idx;
          end
        end
        ST_OWNED: begin
          if (t_own == TR_NONSEQ) begin
            incr_d = (b_own == BU_INCR);
            cnt_d  = load_len - 1'b1;
            if (load_len == CNT_W'(1)) rearb = 1'b1;
            else                       state_d = ST_BURST;
          end else if (t_own == TR_IDLE && !HBUSREQ[hmaster_q]) begin
            rearb = 1'b1;
          end
        end
        ST_BURST: begin
          case (t_own)
            TR_SEQ: begin
              if (cnt_q == CNT_W'(1)) begin
                // An expiring INCR burst keeps the bus if nobody else wants it.
                if (incr_q && !others_pend) cnt_d = HOLD_LOAD;
                else                        rearb = 1'b1;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
            TR_BUSY: ;
            default: begin
              // NONSEQ/IDLE only terminate undefined-length bursts.
              if (incr_q) begin
                if (!HBUSREQ[hmaster_q] || others_pend) rearb = 1'b1;
                else if (t_own == TR_NONSEQ)           cnt_d = HOLD_LOAD - 1'b1;
                else                                    state_d = ST_OWNED;
              end
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
      if (rearb) begin
        cnt_d = '0;
        if (arb_found) begin
          state_d   = ST_OWNED;
          hmaster_d = arb_idx;
          rr_d      = arb_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Address-phase state registers.
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      hmaster_q <= '0;
      rr_q      <= MID_W'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      incr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hmaster_q <= hmaster_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      incr_q    <= incr_d;
    end
  end

  // Data-phase owner follows the address phase by one accepted transfer.
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      dmaster_q <= '0;
      dvalid_q  <= 1'b0;
    end else if (HREADY) begin
      dmaster_q <= hmaster_q;
      dvalid_q  <= grant_active && t_own[1];
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter: round-robin order, burst hold,
// wait states, INCR cap, idle release and asynchronous reset mid-burst.
module tb_ahb_lite_arbiter;

  localparam int NM = 4;

  logic          clk = 1'b0;
  logic          HRESET;
  logic [NM-1:0] HBUSREQ;
  logic [2*NM-1:0] HTRANS_M;
  logic [3*NM-1:0] HBURST_M;
  logic          HREADY;
  logic [NM-1:0] HGRANT;
  logic [1:0]    HMASTER;
  logic [1:0]    HMASTER_D;
  logic          HDATA_VALID;

  int n_asserts = 0;
  int n_fail    = 0;

  ahb_lite_arbiter #(.NUM_MASTERS(NM), .MID_W(2), .MAX_HOLD(16)) dut (
    .clk(clk), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HTRANS_M(HTRANS_M),
    .HBURST_M(HBURST_M), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
    .HMASTER_D(HMASTER_D), .HDATA_VALID(HDATA_VALID)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [1:0] tr, input logic [2:0] bu);
    HTRANS_M[2*idx +: 2] = tr;
    HBURST_M[3*idx +: 3] = bu;
  endtask

  task automatic check_own(input string tag, input logic [3:0] g, input logic [1:0] m);
    check_val({tag, "_grant"}, 32'(HGRANT), 32'(g));
    check_val({tag, "_hmaster"}, 32'(HMASTER), 32'(m));
  endtask

  task automatic do_reset();
    HBUSREQ  = '0;
    HTRANS_M = '0;
    HBURST_M = '0;
    HREADY   = 1'b1;
    HRESET   = 1'b1;
    #2;
    HRESET   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1; HBUSREQ = '0; HTRANS_M = '0; HBURST_M = '0; HREADY = 1'b1;
    #3;
    HRESET = 1'b0;
    check_val("rst_grant", 32'(HGRANT), 32'h0);
    check_val("rst_hmaster", 32'(HMASTER), 32'h0);
    check_val("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    check_val("rst_valid", 32'(HDATA_VALID), 32'h0);

    // All four request, everyone issues SINGLE NONSEQ: order 0,1,2,3,0.
    HBUSREQ  = 4'b1111;
    HTRANS_M = 8'hAA;
    HBURST_M = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_own($sformatf("rr%0d", k), 4'(1 << (k % 4)), 2'(k % 4));
      check_val($sformatf("rr%0d_hmaster_d", k), 32'(HMASTER_D), (k == 0) ? 32'h0 : 32'(k - 1));
      check_val($sformatf("rr%0d_valid", k), 32'(HDATA_VALID), (k == 0) ? 32'h0 : 32'h1);
    end

    // WRAP4 by master 0; master 3 requests and master 0 drops at beat 2.
    step(); do_reset();
    HBUSREQ = 4'b0001;
    step(); check_own("wrap_g", 4'b0001, 2'd0);
    drive(0, 2'b10, 3'b010);
    step(); check_own("wrap_b1", 4'b0001, 2'd0);
    drive(0, 2'b11, 3'b010);
    HBUSREQ = 4'b1000;
    step(); check_own("wrap_b2", 4'b0001, 2'd0);
    step(); check_own("wrap_b3", 4'b0001, 2'd0);
    step(); check_own("wrap_b4", 4'b1000, 2'd3);
    check_val("wrap_hmaster_d", 32'(HMASTER_D), 32'h0);
    check_val("wrap_valid", 32'(HDATA_VALID), 32'h1);

    // INCR4 by master 1 with three wait states on beat 2; master 2 waiting.
    step(); do_reset();
    HBUSREQ = 4'b0010;
    step(); check_own("wait_g", 4'b0010, 2'd1);
    drive(1, 2'b10, 3'b011);
    HBUSREQ = 4'b0110;
    step(); check_own("wait_b1", 4'b0010, 2'd1);
    drive(1, 2'b11, 3'b011);
    HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step();
      check_own($sformatf("wait_ws%0d", w), 4'b0010, 2'd1);
      check_val($sformatf("wait_ws%0d_hmaster_d", w), 32'(HMASTER_D), 32'h1);
      check_val($sformatf("wait_ws%0d_valid", w), 32'(HDATA_VALID), 32'h1);
    end
    HREADY = 1'b1;
    step(); check_own("wait_b2", 4'b0010, 2'd1);
    step(); check_own("wait_b3", 4'b0010, 2'd1);
    step(); check_own("wait_b4", 4'b0100, 2'd2);

    // INCR cap: master 2 streams, master 1 waiting -> handover after 16 beats.
    step(); do_reset();
    HBUSREQ = 4'b0100;
    step(); check_own("cap_g", 4'b0100, 2'd2);
    drive(2, 2'b10, 3'b001);
    HBUSREQ = 4'b0110;
    step();
    drive(2, 2'b11, 3'b001);
    for (int b = 2; b <= 15; b++) step();
    check_own("cap_b15", 4'b0100, 2'd2);
    step(); check_own("cap_b16", 4'b0010, 2'd1);

    // INCR with no other requester keeps the grant past 16 beats.
    step(); do_reset();
    HBUSREQ = 4'b0100;
    step();
    drive(2, 2'b10, 3'b001);
    step();
    drive(2, 2'b11, 3'b001);
    for (int b = 2; b <= 20; b++) step();
    check_own("nocap_b20", 4'b0100, 2'd2);

    // Idle release: master 1 does one SINGLE, then IDLE with request dropped.
    step(); do_reset();
    HBUSREQ = 4'b0010;
    step(); check_own("rel_g", 4'b0010, 2'd1);
    drive(1, 2'b10, 3'b000);
    step(); check_own("rel_single", 4'b0010, 2'd1);
    check_val("rel_single_valid", 32'(HDATA_VALID), 32'h1);
    drive(1, 2'b00, 3'b000);
    HBUSREQ = 4'b0000;
    step(); check_val("rel_grant", 32'(HGRANT), 32'h0);
    check_val("rel_valid1", 32'(HDATA_VALID), 32'h0);
    step(); check_val("rel_valid2", 32'(HDATA_VALID), 32'h0);

    // Reset mid-burst: master 1 INCR8 at beat 3, then master 2 requests.
    step(); do_reset();
    HBUSREQ = 4'b0010;
    step();
    drive(1, 2'b10, 3'b101);
    step();
    drive(1, 2'b11, 3'b101);
    step(); step();
    check_own("mid_pre", 4'b0010, 2'd1);
    check_val("mid_pre_valid", 32'(HDATA_VALID), 32'h1);
    HRESET = 1'b1;
    #1;
    check_val("mid_rst_grant", 32'(HGRANT), 32'h0);
    check_val("mid_rst_hmaster", 32'(HMASTER), 32'h0);
    check_val("mid_rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    check_val("mid_rst_valid", 32'(HDATA_VALID), 32'h0);
    #1;
    HRESET   = 1'b0;
    HTRANS_M = '0;
    HBURST_M = '0;
    HBUSREQ  = 4'b0100;
    step(); check_own("mid_after", 4'b0100, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
